// File: rtl/gf_mult_arb.sv
// Round-robin arbitrated, pipelined GF(2^SYMB_WIDTH) multiplier shared by NUM_REQ requesters.
// Optional grant locking is enabled by defining GF_MULT_ARB_LOCK_EN.

package gf_pkg;
   localparam int SYMB_WIDTH = 8;
   localparam int POLY       = 285;
   localparam int NSYMB      = 1 << SYMB_WIDTH;
   localparam int ORDER      = NSYMB - 1;

   // Antilog table packed as NSYMB symbols; entry ORDER wraps back to alpha^0.
   function automatic logic [NSYMB*SYMB_WIDTH-1:0] gen_alog();
      logic [NSYMB*SYMB_WIDTH-1:0] tab;
      logic [SYMB_WIDTH:0]         x;
      tab = '0;
      x   = (SYMB_WIDTH+1)'(1);
      for (int i = 0; i < NSYMB; i++) begin
         tab[i*SYMB_WIDTH +: SYMB_WIDTH] = x[SYMB_WIDTH-1:0];
         x = x << 1;
         if (x[SYMB_WIDTH]) x = x ^ (SYMB_WIDTH+1)'(POLY);
      end
      return tab;
   endfunction

   function automatic logic [NSYMB*SYMB_WIDTH-1:0] gen_log();
      logic [NSYMB*SYMB_WIDTH-1:0] alog;
      logic [NSYMB*SYMB_WIDTH-1:0] tab;
      logic [SYMB_WIDTH-1:0]       v;
      alog = gen_alog();
      tab  = '0;
      for (int i = 0; i < ORDER; i++) begin
         v = alog[i*SYMB_WIDTH +: SYMB_WIDTH];
         tab[int'(v)*SYMB_WIDTH +: SYMB_WIDTH] = SYMB_WIDTH'(i);
      end
      return tab;
   endfunction

   localparam logic [NSYMB*SYMB_WIDTH-1:0] ALOG_TAB = gen_alog();
   localparam logic [NSYMB*SYMB_WIDTH-1:0] LOG_TAB  = gen_log();

   // Log sum is kept one bit wider so the modulo never sees a truncated value.
   function automatic logic [SYMB_WIDTH-1:0] gf_mult(input logic [SYMB_WIDTH-1:0] a,
                                                     input logic [SYMB_WIDTH-1:0] b);
      logic [SYMB_WIDTH:0]   s;
      logic [SYMB_WIDTH-1:0] p;
      s = {1'b0, LOG_TAB[int'(a)*SYMB_WIDTH +: SYMB_WIDTH]}
        + {1'b0, LOG_TAB[int'(b)*SYMB_WIDTH +: SYMB_WIDTH]};
      if (s >= (SYMB_WIDTH+1)'(ORDER)) s = s - (SYMB_WIDTH+1)'(ORDER);
      p = ALOG_TAB[int'(s)*SYMB_WIDTH +: SYMB_WIDTH];
      if (a == '0 || b == '0) p = '0;
      return p;
   endfunction
endpackage

module gf_mult_arb
   import gf_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int PIPE_LAT = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_vld,
   output logic [NUM_REQ-1:0]            req_rdy,
   input  logic [NUM_REQ*SYMB_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*SYMB_WIDTH-1:0] req_b,
   input  logic [NUM_REQ-1:0]            req_lock,
   output logic [NUM_REQ-1:0]            res_vld,
   output logic [SYMB_WIDTH-1:0]         res_symb,
   output logic                          busy
);
   localparam int PW = $clog2(NUM_REQ);

   logic [PW-1:0]         r_ptr;
   logic [PW-1:0]         w_gnt_idx;
   logic                  w_gnt_any;
   logic                  w_locked;
   logic [PW-1:0]         w_lock_own;
   logic [SYMB_WIDTH-1:0] w_a;
   logic [SYMB_WIDTH-1:0] w_b;
   logic                  w_last_vld;
   logic [PW-1:0]         w_last_own;
   logic [SYMB_WIDTH-1:0] w_last_prod;
   logic                  w_any_stage;

`ifdef GF_MULT_ARB_LOCK_EN
   logic          r_lock_vld;
   logic [PW-1:0] r_lock_own;

   // The owner keeps the lock while it still holds lock or has an operand pending;
   // a pending operand with lock low is its releasing transfer.
   assign w_lock_own = r_lock_own;
   assign w_locked   = r_lock_vld & (req_lock[r_lock_own] | req_vld[r_lock_own]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lock_vld <= 1'b0;
         r_lock_own <= '0;
      end else if (w_gnt_any) begin
         r_lock_vld <= req_lock[w_gnt_idx];
         r_lock_own <= w_gnt_idx;
      end else if (!w_locked) begin
         r_lock_vld <= 1'b0;
      end
   end
`else
   logic w_unused_lock;
   assign w_unused_lock = ^req_lock;
   assign w_lock_own    = '0;
   assign w_locked      = 1'b0;
`endif

   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      if (w_locked) begin
         w_gnt_any = req_vld[w_lock_own];
         w_gnt_idx = w_lock_own;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            logic [PW:0] w_sum;
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NUM_REQ)) w_sum = w_sum - (PW+1)'(NUM_REQ);
            if (!w_gnt_any && req_vld[w_sum[PW-1:0]]) begin
               w_gnt_any = 1'b1;
               w_gnt_idx = w_sum[PW-1:0];
            end
         end
      end
   end

   always_comb begin
      req_rdy            = '0;
      req_rdy[w_gnt_idx] = w_gnt_any;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (w_gnt_any && !w_locked) begin
         r_ptr <= (w_gnt_idx == PW'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
      end
   end

   assign w_a = req_a[w_gnt_idx*SYMB_WIDTH +: SYMB_WIDTH];
   assign w_b = req_b[w_gnt_idx*SYMB_WIDTH +: SYMB_WIDTH];

   generate
      if (PIPE_LAT == 1) begin : g_lat1
         logic                  r_vld;
         logic [PW-1:0]         r_own;
         logic [SYMB_WIDTH-1:0] r_prod;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_vld  <= 1'b0;
               r_own  <= '0;
               r_prod <= '0;
            end else begin
               r_vld  <= w_gnt_any;
               r_own  <= w_gnt_any ? w_gnt_idx : '0;
               r_prod <= w_gnt_any ? gf_mult(w_a, w_b) : '0;
            end
         end

         assign w_last_vld  = r_vld;
         assign w_last_own  = r_own;
         assign w_last_prod = r_prod;
         assign w_any_stage = r_vld;
      end else begin : g_latn
         logic [PIPE_LAT-1:0]   r_vld;
         logic [PW-1:0]         r_own  [PIPE_LAT];
         logic [SYMB_WIDTH-1:0] r_op_a;
         logic [SYMB_WIDTH-1:0] r_op_b;
         // r_prod[s-1] holds the product of stage s; invalid stages carry zero.
         logic [SYMB_WIDTH-1:0] r_prod [PIPE_LAT-1];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_vld  <= '0;
               r_op_a <= '0;
               r_op_b <= '0;
               for (int s = 0; s < PIPE_LAT; s++) r_own[s] <= '0;
               for (int s = 0; s < PIPE_LAT-1; s++) r_prod[s] <= '0;
            end else begin
               r_vld[0]  <= w_gnt_any;
               r_own[0]  <= w_gnt_any ? w_gnt_idx : '0;
               r_op_a    <= w_gnt_any ? w_a : '0;
               r_op_b    <= w_gnt_any ? w_b : '0;
               r_vld[1]  <= r_vld[0];
               r_own[1]  <= r_own[0];
               r_prod[0] <= r_vld[0] ? gf_mult(r_op_a, r_op_b) : '0;
               for (int s = 2; s < PIPE_LAT; s++) begin
                  r_vld[s]    <= r_vld[s-1];
                  r_own[s]    <= r_own[s-1];
                  r_prod[s-1] <= r_prod[s-2];
               end
            end
         end

         assign w_last_vld  = r_vld[PIPE_LAT-1];
         assign w_last_own  = r_own[PIPE_LAT-1];
         assign w_last_prod = r_prod[PIPE_LAT-2];
         assign w_any_stage = |r_vld;
      end
   endgenerate

   always_comb begin
      res_vld = '0;
      if (w_last_vld) res_vld[w_last_own] = 1'b1;
   end

   assign res_symb = w_last_prod;
   assign busy     = (|req_vld) | w_any_stage;

endmodule

// File: tb/tb_gf_mult_arb.sv
// Self-checking bench for gf_mult_arb: vector table, random ops, fairness, reset and lock sequences.
// Lock expectations follow GF_MULT_ARB_LOCK_EN as defined for the build.

module tb_gf_mult_arb;
   localparam int NUM_REQ  = 4;
   localparam int PIPE_LAT = 2;
   localparam int SW       = 8;
   localparam int W        = 32 + NUM_REQ + SW;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_vld;
   logic [NUM_REQ-1:0]    req_rdy;
   logic [NUM_REQ*SW-1:0] req_a;
   logic [NUM_REQ*SW-1:0] req_b;
   logic [NUM_REQ-1:0]    req_lock;
   logic [NUM_REQ-1:0]    res_vld;
   logic [SW-1:0]         res_symb;
   logic                  busy;

   logic [SW-1:0] op_a [NUM_REQ];
   logic [SW-1:0] op_b [NUM_REQ];
   logic [W-1:0]  exp_q[$];
   int            cyc    = 0;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_a[i*SW +: SW] = op_a[i];
         req_b[i*SW +: SW] = op_b[i];
      end
   end

   gf_mult_arb #(.NUM_REQ(NUM_REQ), .PIPE_LAT(PIPE_LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .req_vld  (req_vld),
      .req_rdy  (req_rdy),
      .req_a    (req_a),
      .req_b    (req_b),
      .req_lock (req_lock),
      .res_vld  (res_vld),
      .res_symb (res_symb),
      .busy     (busy)
   );

   // Shift-and-add reference multiply modulo x^8+x^4+x^3+x^2+1.
   function automatic logic [SW-1:0] gf_mul(input logic [SW-1:0] a, input logic [SW-1:0] b);
      logic [SW:0]   sh;
      logic [SW-1:0] p;
      p  = '0;
      sh = {1'b0, a};
      for (int i = 0; i < SW; i++) begin
         if (b[i]) p = p ^ sh[SW-1:0];
         sh = sh << 1;
         if (sh[SW]) sh = sh ^ 9'h11D;
      end
      return p;
   endfunction

   // Scoreboard: each entry is {due cycle, one-hot owner, product}.
   always @(negedge clk) begin
      logic [W-1:0] ent;
      if (!rst) begin
         if (exp_q.size() > 0 && int'(exp_q[0][W-1:NUM_REQ+SW]) == cyc) begin
            ent = exp_q.pop_front();
            checks++;
            if (res_vld !== ent[NUM_REQ+SW-1:SW] || res_symb !== ent[SW-1:0]) begin
               errors++;
               $display("FAIL result cyc=%0d got vld=%b symb=%h want vld=%b symb=%h",
                        cyc, res_vld, res_symb, ent[NUM_REQ+SW-1:SW], ent[SW-1:0]);
            end
         end else begin
            checks++;
            if (res_vld !== '0 || res_symb !== '0) begin
               errors++;
               $display("FAIL idle_out cyc=%0d got vld=%b symb=%h want vld=0 symb=00",
                        cyc, res_vld, res_symb);
            end
         end
         if (exp_q.size() > 0 && int'(exp_q[0][W-1:NUM_REQ+SW]) < cyc) begin
            ent = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing cyc=%0d got none want vld=%b symb=%h",
                     cyc, ent[NUM_REQ+SW-1:SW], ent[SW-1:0]);
         end
      end
   end

   function automatic int oh_idx(input logic [NUM_REQ-1:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < NUM_REQ; i++) if (oh[i]) r = i;
      return r;
   endfunction

   task automatic rand_ops();
      for (int i = 0; i < NUM_REQ; i++) begin
         op_a[i] = 8'($urandom_range(0, 255));
         op_b[i] = 8'($urandom_range(0, 255));
      end
   endtask

   // Called at posedge+1; drives one cycle, checks the grant, pushes the expected result.
   task automatic step(input logic [NUM_REQ-1:0] vld, input logic [NUM_REQ-1:0] lock,
                       input logic [NUM_REQ-1:0] exp_gnt, input bit use_tab,
                       input logic [SW-1:0] tab_symb, input string name);
      int            g;
      logic [SW-1:0] e;
      req_vld  = vld;
      req_lock = lock;
      @(negedge clk);
      checks++;
      if (req_rdy !== exp_gnt) begin
         errors++;
         $display("FAIL %s req_rdy got %b want %b", name, req_rdy, exp_gnt);
      end
      if (vld != '0) begin
         checks++;
         if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy got %b want 1", name, busy);
         end
      end
      @(posedge clk);
      #1;
      if (exp_gnt != '0) begin
         g = oh_idx(exp_gnt);
         e = use_tab ? tab_symb : gf_mul(op_a[g], op_b[g]);
         exp_q.push_back({32'(cyc + PIPE_LAT - 1), exp_gnt, e});
      end
   endtask

   task automatic idle(input int n);
      req_vld  = '0;
      req_lock = '0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_quiet(input string name);
      @(negedge clk);
      checks++;
      if (res_vld !== '0 || busy !== 1'b0 || res_symb !== '0) begin
         errors++;
         $display("FAIL %s got vld=%b busy=%b symb=%h want vld=0 busy=0 symb=00",
                  name, res_vld, busy, res_symb);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      req_vld  = '0;
      req_lock = '0;
      exp_q.delete();
      check_quiet("in_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   typedef struct {
      int          r;
      logic [SW-1:0] a;
      logic [SW-1:0] b;
      logic [SW-1:0] p;
   } vec_t;

   vec_t tab [8];

   initial begin
      logic [NUM_REQ-1:0] oh;
      int                 r;
      tab[0] = '{0, 8'h80, 8'h02, 8'h1D};
      tab[1] = '{2, 8'h00, 8'h57, 8'h00};
      tab[2] = '{2, 8'h03, 8'h07, 8'h09};
      tab[3] = '{1, 8'hFF, 8'h01, 8'hFF};
      tab[4] = '{3, 8'h01, 8'h53, 8'h53};
      tab[5] = '{1, 8'h57, 8'h00, 8'h00};
      tab[6] = '{0, 8'h02, 8'h02, 8'h04};
      tab[7] = '{3, 8'h80, 8'h80, 8'h13};

      rst      = 1'b0;
      req_vld  = '0;
      req_lock = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      #2;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (res_vld !== '0 || res_symb !== '0 || busy !== 1'b0 || req_rdy !== '0) begin
         errors++;
         $display("FAIL reset_state got vld=%b symb=%h busy=%b rdy=%b want all zero",
                  res_vld, res_symb, busy, req_rdy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Vector table, issued back to back.
      for (int i = 0; i < 8; i++) begin
         oh = NUM_REQ'(1 << tab[i].r);
         op_a[tab[i].r] = tab[i].a;
         op_b[tab[i].r] = tab[i].b;
         step(oh, '0, oh, 1'b1, tab[i].p, "table");
      end
      idle(PIPE_LAT + 2);

      // Random single-requester ops against the reference multiply.
      for (int i = 0; i < 16; i++) begin
         rand_ops();
         r  = $urandom_range(0, NUM_REQ - 1);
         oh = NUM_REQ'(1 << r);
         step(oh, '0, oh, 1'b0, '0, "random");
      end
      idle(PIPE_LAT + 2);

      // Fairness from reset with all requesters valid.
      do_reset();
      for (int k = 0; k < 8; k++) begin
         rand_ops();
         step('1, '0, NUM_REQ'(1 << (k % NUM_REQ)), 1'b0, '0, "fair");
      end
      idle(PIPE_LAT + 2);

      // Reset with two products in flight; pointer left at 3 beforehand.
      rand_ops();
      step(4'b0010, '0, 4'b0010, 1'b0, '0, "pre_rst");
      step(4'b0100, '0, 4'b0100, 1'b0, '0, "pre_rst");
      do_reset();
      repeat (4) check_quiet("post_rst");
      @(posedge clk);
      #1;
      rand_ops();
      step('1, '0, 4'b0001, 1'b0, '0, "ptr_after_rst");
      idle(PIPE_LAT + 2);

      // Sparse wrap: pointer at 1 -> grant 2 (ptr 3) -> grant 1 (ptr 2) -> grant 3.
      rand_ops();
      step(4'b0100, '0, 4'b0100, 1'b0, '0, "wrap_set");
      step(4'b0010, '0, 4'b0010, 1'b0, '0, "wrap_grant1");
      step(4'b1010, '0, 4'b1000, 1'b0, '0, "wrap_grant3");
      step(4'b0010, '0, 4'b0010, 1'b0, '0, "wrap_after");
      idle(PIPE_LAT + 2);

      // Lock sequence; pointer first moved to 1.
      rand_ops();
      step(4'b0001, '0, 4'b0001, 1'b0, '0, "lock_set");
`ifdef GF_MULT_ARB_LOCK_EN
      step(4'b0011, 4'b0010, 4'b0010, 1'b0, '0, "lock_take");
      step(4'b0011, 4'b0010, 4'b0010, 1'b0, '0, "lock_hold");
      step(4'b0011, 4'b0010, 4'b0010, 1'b0, '0, "lock_hold");
      step(4'b0001, 4'b0010, 4'b0000, 1'b0, '0, "lock_holdoff");
      step(4'b0011, 4'b0000, 4'b0010, 1'b0, '0, "lock_release");
      step(4'b0011, 4'b0000, 4'b0001, 1'b0, '0, "lock_next");
      step(4'b0011, 4'b0000, 4'b0010, 1'b0, '0, "lock_rr");
`else
      step(4'b0011, 4'b0010, 4'b0010, 1'b0, '0, "nolock_rr");
      step(4'b0011, 4'b0010, 4'b0001, 1'b0, '0, "nolock_rr");
      step(4'b0001, 4'b0010, 4'b0001, 1'b0, '0, "nolock_rr");
      step(4'b0011, 4'b0000, 4'b0010, 1'b0, '0, "nolock_rr");
      step(4'b0011, 4'b0000, 4'b0001, 1'b0, '0, "nolock_rr");
`endif
      idle(PIPE_LAT + 3);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
